// File: rtl/fx2_out_cmd_reader.sv
// Slave-FIFO command reader: pulls 3-byte write commands (A5, 1000_0aaa, data)
// from FX2 EP4 and applies them to an 8 x 8 configuration register file.
module fx2_out_cmd_reader (
    input  logic       FX2_IFCLK,
    input  logic       MAX2_nRESET,
    input  logic [1:0] MAX2_MODE,
    input  logic       MAX2_FIFO_DIR,
    input  logic [2:0] MAX2_REG_ADDR,
    input  logic [7:0] FX2_FD,
    input  logic       FX2_FLAGC,
    output logic       FX2_SLOE,
    output logic       FX2_SLRD,
    output logic [1:0] FX2_FIFOADDR,
    output logic       CFG_WE,
    output logic [2:0] CFG_ADDR,
    output logic [7:0] CFG_DATA,
    output logic [7:0] REG_RD_DATA,
    output logic       EXT_SOUND_ENABLE,
    output logic [7:0] BAD_CMD_COUNT,
    output logic [1:0] DBG_STATE
);

    // Handshake: FX2_SLRD low for exactly one cycle means FX2_FD is consumed on
    // the closing edge (accept); a new strobe only starts from FX2_SLRD high
    // with FX2_FLAGC set, so strobes are never back to back.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       en;
    logic       accept;
    logic       bad_evt;
    logic       slrd_nxt;
    logic [7:0] tmo, tmo_nxt;
    logic [2:0] addr_q, addr_nxt;
    logic [7:0] data_q, data_nxt;
    logic [7:0] regs [8];

    assign en           = (MAX2_MODE == 2'd0) && MAX2_FIFO_DIR;
    assign FX2_SLOE     = ~en;
    assign FX2_FIFOADDR = 2'b01;
    assign accept       = en && !FX2_SLRD;
    assign DBG_STATE    = state;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        tmo_nxt   = tmo;
        bad_evt   = 1'b0;
        slrd_nxt  = !(en && (state != COMMIT) && FX2_SLRD && FX2_FLAGC);
        case (state)
            HUNT: begin
                tmo_nxt = 8'd0;
                if (accept && (FX2_FD == 8'hA5)) state_nxt = ADDR;
            end
            ADDR, DATA: begin
                if (!en) begin
                    state_nxt = HUNT;
                    bad_evt   = 1'b1;
                    tmo_nxt   = 8'd0;
                end else if (accept) begin
                    tmo_nxt = 8'd0;
                    if (state == DATA) begin
                        data_nxt  = FX2_FD;
                        state_nxt = COMMIT;
                    end else if (FX2_FD[7] && (FX2_FD[6:3] == 4'd0)) begin
                        addr_nxt  = FX2_FD[2:0];
                        state_nxt = DATA;
                    end else begin
                        state_nxt = HUNT;
                        bad_evt   = 1'b1;
                    end
                end else if (tmo == 8'd254) begin
                    // this edge would take the idle counter to 255
                    state_nxt = HUNT;
                    bad_evt   = 1'b1;
                    tmo_nxt   = 8'd0;
                end else begin
                    tmo_nxt = tmo + 8'd1;
                end
            end
            COMMIT:  state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET) begin
        if (!MAX2_nRESET) begin
            state         <= HUNT;
            FX2_SLRD      <= 1'b1;
            tmo           <= 8'd0;
            addr_q        <= 3'd0;
            data_q        <= 8'd0;
            CFG_WE        <= 1'b0;
            CFG_ADDR      <= 3'd0;
            CFG_DATA      <= 8'd0;
            BAD_CMD_COUNT <= 8'd0;
        end else begin
            state    <= state_nxt;
            FX2_SLRD <= slrd_nxt;
            tmo      <= tmo_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
            CFG_WE   <= (state == COMMIT);
            if (state == COMMIT) begin
                CFG_ADDR <= addr_q;
                CFG_DATA <= data_q;
            end
            if (bad_evt && (BAD_CMD_COUNT != 8'hFF))
                BAD_CMD_COUNT <= BAD_CMD_COUNT + 8'd1;
        end
    end

    // The register file is written from the CFG_* outputs, so a read during
    // the CFG_WE cycle still returns the old contents.
    always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET) begin
        if (!MAX2_nRESET) begin
            regs[0] <= 8'h01;
            for (int i = 1; i < 8; i++) regs[i] <= 8'h00;
        end else if (CFG_WE) begin
            regs[CFG_ADDR] <= CFG_DATA;
        end
    end

    assign REG_RD_DATA      = regs[MAX2_REG_ADDR];
    assign EXT_SOUND_ENABLE = regs[0][0];

endmodule
